// File: rtl/wb_unified_mem_arbiter.sv
// Two-master (I fetch / D load-store) Wishbone arbiter onto one unified memory port.
// Fair round-robin on ties, combinational routing while granted, and a bus timeout abort.
module wb_unified_mem_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_adr_i,
  input  logic        i_cyc_i,
  input  logic        i_stb_i,
  output logic [31:0] i_dat_o,
  output logic        i_ack_o,
  output logic        i_err_o,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY_I = 2'b01, BUSY_D = 2'b10} state_e;

  state_e        state_q, state_d;
  logic          last_d_q, last_d_d;  // 1: D held the most recent grant
  logic [CW-1:0] cnt_q, cnt_d;
  logic          i_req, d_req, gcyc, tmo, ack_fwd, err_fwd;

  assign i_req   = i_cyc_i & i_stb_i;
  assign d_req   = d_cyc_i & d_stb_i;
  assign grant_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    i_dat_o  = '0;
    d_dat_o  = '0;
    i_ack_o  = 1'b0;
    i_err_o  = 1'b0;
    d_ack_o  = 1'b0;
    d_err_o  = 1'b0;
    gcyc     = 1'b0;
    tmo      = 1'b0;
    ack_fwd  = 1'b0;
    err_fwd  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // D wins unless I is also asking and D had the previous turn
        if (d_req && (!i_req || !last_d_q)) begin
          state_d  = BUSY_D;
          last_d_d = 1'b1;
        end else if (i_req) begin
          state_d  = BUSY_I;
          last_d_d = 1'b0;
        end
      end
      BUSY_I: begin
        s_adr_o = i_adr_i;
        s_sel_o = 4'hF;
        s_cyc_o = i_cyc_i;
        s_stb_o = i_stb_i;
        gcyc    = i_cyc_i;
        i_dat_o = s_dat_i;
      end
      BUSY_D: begin
        s_adr_o = d_adr_i;
        s_dat_o = d_dat_i;
        s_we_o  = d_we_i;
        s_sel_o = d_sel_i;
        s_cyc_o = d_cyc_i;
        s_stb_o = d_stb_i;
        gcyc    = d_cyc_i;
        d_dat_o = s_dat_i;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      tmo     = gcyc & ~s_ack_i & ~s_err_i & (cnt_q == CW'(TIMEOUT - 1));
      err_fwd = gcyc & (s_err_i | tmo);
      ack_fwd = gcyc & s_ack_i & ~s_err_i;
      if (tmo) begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
      end
      // A master abandoning its cycle ends the transfer; stray acks are dropped
      if (!gcyc || s_ack_i || s_err_i || tmo) state_d = IDLE;
      else                                    cnt_d   = cnt_q + CW'(1);
      if (state_q == BUSY_I) begin
        i_ack_o = ack_fwd;
        i_err_o = err_fwd;
      end else begin
        d_ack_o = ack_fwd;
        d_err_o = err_fwd;
      end
    end
  end
endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Directed bench for wb_unified_mem_arbiter: cycle vector table plus
// hand sequences for round-robin, timeout and asynchronous reset abort.
module tb_wb_unified_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] i_adr_i, i_dat_o, d_adr_i, d_dat_i, d_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic        i_cyc_i, i_stb_i, i_ack_o, i_err_o;
  logic        d_we_i, d_cyc_i, d_stb_i, d_ack_o, d_err_o;
  logic [3:0]  d_sel_i, s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [1:0]  grant_o;

  int errors = 0, checks = 0;

  wb_unified_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_adr_i(i_adr_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir, dr, dwe;
    logic [3:0]  dsel;
    logic        sa, se;
    logic [31:0] sdat;
    logic [1:0]  grant;
    logic        scyc, swe;
    logic [3:0]  ssel;
    logic [31:0] sadr, sdo;
    logic        iack, ierr, dack, derr;
    logic [31:0] idat, ddat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ir, dr, dwe, input logic [3:0] dsel, input logic sa, se, input logic [31:0] sdat,
    input logic [1:0] grant, input logic scyc, swe, input logic [3:0] ssel,
    input logic [31:0] sadr, sdo, input logic iack, ierr, dack, derr, input logic [31:0] idat, ddat);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dwe = dwe; v.dsel = dsel; v.sa = sa; v.se = se; v.sdat = sdat;
    v.grant = grant; v.scyc = scyc; v.swe = swe; v.ssel = ssel; v.sadr = sadr; v.sdo = sdo;
    v.iack = iack; v.ierr = ierr; v.dack = dack; v.derr = derr; v.idat = idat; v.ddat = ddat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, dr, dwe, input logic [3:0] dsel,
                       input logic sa, se, input logic [31:0] sd);
    i_cyc_i = ir; i_stb_i = ir;
    d_cyc_i = dr; d_stb_i = dr; d_we_i = dwe; d_sel_i = dsel;
    s_ack_i = sa; s_err_i = se; s_dat_i = sd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seq[$];
    logic [1:0] prev;
    int bcnt, errcyc, derr_cnt;
    logic stb_err, ipend_bad, igrant, both_ack;

    i_adr_i = 32'h100; d_adr_i = 32'h1000; d_dat_i = 32'h1;

    // Reset phase with live inputs: everything must stay quiet
    drive(1, 1, 1, 4'hF, 1, 1, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    chk("reset_grant", 128'(grant_o), 128'(2'b00));
    chk("reset_slave", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}), 128'(0));
    chk("reset_master", 128'({i_ack_o, i_err_o, d_ack_o, d_err_o, i_dat_o, d_dat_o}), 128'(0));
    drive(0, 0, 0, 4'h0, 0, 0, 32'h0);
    rst_n = 1'b1;

    // ir dr we sel ack err sdat | grant cyc we sel adr sdo | iack ierr dack derr idat ddat
    tbl.push_back(mk(0,0,0,4'h0,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,4'h0,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,4'h0,0,0,32'h0,  2'b01,1,0,4'hF,32'h100,32'h0,  0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,4'h0,1,0,32'h13, 2'b01,1,0,4'hF,32'h100,32'h0,  1,0,0,0,32'h13,32'h0));
    tbl.push_back(mk(0,0,0,4'h0,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,1,1,4'hF,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,1,1,4'hF,0,0,32'h0,  2'b10,1,1,4'hF,32'h1000,32'h1, 0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,1,1,4'hF,1,0,32'hAA, 2'b10,1,1,4'hF,32'h1000,32'h1, 0,0,1,0,32'h0,32'hAA));
    tbl.push_back(mk(1,0,0,4'h0,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,4'h0,0,0,32'h0,  2'b01,1,0,4'hF,32'h100,32'h0,  0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,4'h0,1,0,32'h55, 2'b01,1,0,4'hF,32'h100,32'h0,  1,0,0,0,32'h55,32'h0));
    tbl.push_back(mk(0,0,0,4'h0,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(0,1,1,4'h4,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(0,1,1,4'h4,1,1,32'h0,  2'b10,1,1,4'h4,32'h1000,32'h1, 0,0,0,1,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,4'h0,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,4'h0,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,4'h0,0,0,32'h0,  2'b01,1,0,4'hF,32'h100,32'h0,  0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,4'h0,1,0,32'h0,  2'b01,0,0,4'hF,32'h100,32'h0,  0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,4'h0,0,0,32'h0,  2'b00,0,0,4'h0,32'h0,32'h0,    0,0,0,0,32'h0,32'h0));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].ir, tbl[i].dr, tbl[i].dwe, tbl[i].dsel, tbl[i].sa, tbl[i].se, tbl[i].sdat);
      @(negedge clk);
      chk($sformatf("row%0d_grant", i), 128'(grant_o), 128'(tbl[i].grant));
      chk($sformatf("row%0d_slave", i),
          128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}),
          128'({tbl[i].scyc, tbl[i].scyc, tbl[i].swe, tbl[i].ssel, tbl[i].sadr, tbl[i].sdo}));
      chk($sformatf("row%0d_master", i),
          128'({i_ack_o, i_err_o, d_ack_o, d_err_o, i_dat_o, d_dat_o}),
          128'({tbl[i].iack, tbl[i].ierr, tbl[i].dack, tbl[i].derr, tbl[i].idat, tbl[i].ddat}));
    end

    // Both masters request continuously; slave acks every granted cycle
    prev = 2'b00; both_ack = 1'b0;
    for (int k = 0; k < 40 && seq.size() < 6; k++) begin
      @(posedge clk); #1;
      drive(1, 1, 0, 4'hF, grant_o != 2'b00, 0, 32'h0);
      @(negedge clk);
      if (i_ack_o && d_ack_o) both_ack = 1'b1;
      if (grant_o != 2'b00 && prev == 2'b00) seq.push_back(int'(grant_o));
      prev = grant_o;
    end
    chk("alt_count", 128'(seq.size()), 128'(6));
    chk("alt_no_dual_ack", 128'(both_ack), 128'(0));
    foreach (seq[i]) chk($sformatf("alt_grant%0d", i), 128'(seq[i]), 128'((i % 2 == 0) ? 2 : 1));
    @(posedge clk); #1;
    drive(0, 0, 0, 4'h0, 0, 0, 32'h0);
    @(negedge clk);
    chk("alt_idle", 128'(grant_o), 128'(2'b00));

    // Timeout: D granted (I had last turn), slave silent, I waits
    @(posedge clk); #1;
    drive(1, 1, 1, 4'h3, 0, 0, 32'h0);
    bcnt = 0; errcyc = -1; derr_cnt = 0; stb_err = 1'b1; ipend_bad = 1'b0; igrant = 1'b0;
    for (int k = 0; k < 30 && !igrant; k++) begin
      @(posedge clk); #1;
      if (errcyc >= 0) drive(1, 0, 0, 4'h0, grant_o == 2'b01, 0, 32'h0);
      else             drive(1, 1, 1, 4'h3, 0, 0, 32'h0);
      @(negedge clk);
      if (grant_o == 2'b10) begin
        bcnt++;
        if (i_ack_o || i_err_o) ipend_bad = 1'b1;
        if (d_err_o) begin
          derr_cnt++;
          if (errcyc < 0) begin
            errcyc  = bcnt;
            stb_err = s_stb_o | s_cyc_o;
          end
        end
      end
      if (grant_o == 2'b01 && errcyc >= 0) igrant = 1'b1;
    end
    chk("tmo_err_cycle", 128'(errcyc), 128'(8));
    chk("tmo_err_pulses", 128'(derr_cnt), 128'(1));
    chk("tmo_stb_low", 128'(stb_err), 128'(0));
    chk("tmo_i_held", 128'(ipend_bad), 128'(0));
    chk("tmo_i_granted", 128'(igrant), 128'(1));
    chk("tmo_i_ack", 128'({i_ack_o, i_err_o}), 128'(2'b10));
    @(posedge clk); #1;
    drive(0, 0, 0, 4'h0, 0, 0, 32'h0);
    @(negedge clk);

    // Asynchronous reset in the middle of a D transfer
    @(posedge clk); #1;
    drive(0, 1, 1, 4'hF, 0, 0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_grant", 128'(grant_o), 128'(2'b10));
    #1;
    s_ack_i = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("rst_abort", 128'({grant_o, s_cyc_o, s_stb_o, d_ack_o, d_err_o, i_ack_o, i_err_o}), 128'(0));
    @(negedge clk);
    drive(0, 1, 1, 4'hF, 0, 0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_restart_grant", 128'(grant_o), 128'(2'b10));
    #1;
    s_ack_i = 1'b1;
    #1;
    chk("rst_restart_ack", 128'({d_ack_o, s_cyc_o}), 128'(2'b11));
    @(posedge clk); #1;
    drive(0, 0, 0, 4'h0, 0, 0, 32'h0);
    @(negedge clk);
    chk("final_idle", 128'(grant_o), 128'(2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
